// File: rtl/gb_io_responder_pkg.sv
// Shared CPU package: high-page address map, interrupt bit order and timer tap encoding.
package gb_io_responder_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IRQ_W  = 5;

  localparam logic [ADDR_W-1:0] ADDR_DIV       = 16'hFF04;
  localparam logic [ADDR_W-1:0] ADDR_TIMA      = 16'hFF05;
  localparam logic [ADDR_W-1:0] ADDR_TMA       = 16'hFF06;
  localparam logic [ADDR_W-1:0] ADDR_TAC       = 16'hFF07;
  localparam logic [ADDR_W-1:0] ADDR_IF        = 16'hFF0F;
  localparam logic [ADDR_W-1:0] ADDR_HRAM_BASE = 16'hFF80;

  typedef enum logic [2:0] {
    IRQ_VBLANK = 3'd0,
    IRQ_STAT,
    IRQ_TIMER,
    IRQ_SERIAL,
    IRQ_JOYPAD
  } irq_bit_t;

  // TAC[1:0] selects which divider bit clocks TIMA
  typedef enum logic [1:0] {
    TAC_CLK_1024 = 2'b00,
    TAC_CLK_16   = 2'b01,
    TAC_CLK_64   = 2'b10,
    TAC_CLK_256  = 2'b11
  } tac_clk_sel_t;

  typedef struct packed {
    logic div;
    logic tima;
    logic tma;
    logic tac;
  } timer_wr_t;

endpackage

// File: rtl/gb_io_responder_timer.sv
// Divider, TIMA/TMA/TAC and falling-edge tick detection.
// GB_TIMER_RELOAD_DELAY_EN adds the 4-clk TIMA=0x00 window before the TMA reload.
module gb_timer
  import gb_io_responder_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  timer_wr_t  wr,
  input  logic [7:0] wdata,
  output logic [7:0] div_q,
  output logic [7:0] tima_q,
  output logic [7:0] tma_q,
  output logic [2:0] tac_q,
  output logic       timer_irq_c
);

  logic [DIV_WIDTH-1:0] div_cnt, div_nxt;
  logic [7:0]           tima_nxt, tma_nxt;
  logic [2:0]           tac_nxt;
  logic                 fall;
`ifdef GB_TIMER_RELOAD_DELAY_EN
  logic                 rl_pend, rl_pend_nxt;
  logic [1:0]           rl_cnt, rl_cnt_nxt;
`endif

  function automatic logic tick_of(input logic [DIV_WIDTH-1:0] d, input logic [2:0] t);
    logic b;
    b = d[9];
    case (tac_clk_sel_t'(t[1:0]))
      TAC_CLK_16:  b = d[3];
      TAC_CLK_64:  b = d[5];
      TAC_CLK_256: b = d[7];
      default:     b = d[9];
    endcase
    return t[2] & b;
  endfunction

  assign div_q = div_cnt[DIV_WIDTH-1 -: 8];

  // Edge is taken between current and next divider/TAC so DIV/TAC writes can glitch a tick
  always_comb begin
    div_nxt     = wr.div ? '0 : div_cnt + DIV_WIDTH'(1);
    tac_nxt     = wr.tac ? wdata[2:0] : tac_q;
    tma_nxt     = wr.tma ? wdata : tma_q;
    fall        = tick_of(div_cnt, tac_q) & ~tick_of(div_nxt, tac_nxt);
    tima_nxt    = tima_q;
    timer_irq_c = 1'b0;
`ifdef GB_TIMER_RELOAD_DELAY_EN
    rl_pend_nxt = rl_pend;
    rl_cnt_nxt  = rl_cnt;
    if (wr.tima) begin
      tima_nxt    = wdata;
      rl_pend_nxt = 1'b0;
      rl_cnt_nxt  = 2'd0;
    end else if (rl_pend) begin
      if (rl_cnt == 2'd3) begin
        tima_nxt    = tma_nxt;
        timer_irq_c = 1'b1;
        rl_pend_nxt = 1'b0;
        rl_cnt_nxt  = 2'd0;
      end else begin
        rl_cnt_nxt = rl_cnt + 2'd1;
      end
    end else if (fall) begin
      tima_nxt = tima_q + 8'd1;
      if (tima_q == 8'hFF) begin
        rl_pend_nxt = 1'b1;
        rl_cnt_nxt  = 2'd0;
      end
    end
`else
    if (wr.tima) begin
      tima_nxt = wdata;
    end else if (fall) begin
      if (tima_q == 8'hFF) begin
        tima_nxt    = tma_nxt;
        timer_irq_c = 1'b1;
      end else begin
        tima_nxt = tima_q + 8'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      tima_q  <= 8'h00;
      tma_q   <= 8'h00;
      tac_q   <= 3'b000;
`ifdef GB_TIMER_RELOAD_DELAY_EN
      rl_pend <= 1'b0;
      rl_cnt  <= 2'd0;
`endif
    end else begin
      div_cnt <= div_nxt;
      tima_q  <= tima_nxt;
      tma_q   <= tma_nxt;
      tac_q   <= tac_nxt;
`ifdef GB_TIMER_RELOAD_DELAY_EN
      rl_pend <= rl_pend_nxt;
      rl_cnt  <= rl_cnt_nxt;
`endif
    end
  end

endmodule

// File: rtl/gb_io_responder.sv
// High-page bus responder: address decode, HRAM, IF register and registered read mux.
// Optional macro GB_TIMER_RELOAD_DELAY_EN is consumed by gb_timer.
module gb_io_responder
  import gb_io_responder_pkg::*;
#(
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned HRAM_DEPTH = 127
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_req_i,
  input  logic              bus_wr_i,
  input  logic [ADDR_W-1:0] bus_addr_i,
  input  logic [DATA_W-1:0] bus_wdata_i,
  output logic [DATA_W-1:0] bus_rdata_o,
  output logic              bus_rvalid_o,
  output logic              bus_hit_o,
  input  logic [IRQ_W-1:0]  irq_req_i,
  input  logic [IRQ_W-1:0]  irq_ack_i,
  output logic [IRQ_W-1:0]  if_o
);

  localparam int unsigned HRAM_AW = $clog2(HRAM_DEPTH);

  logic [DATA_W-1:0] hram [HRAM_DEPTH];
  logic [ADDR_W-1:0] hram_off;
  logic              hram_hit, hram_we, wr_req, if_wr, hit_c, timer_irq_c;
  logic [DATA_W-1:0] rd_c, div_q, tima_q, tma_q;
  logic [2:0]        tac_q;
  logic [IRQ_W-1:0]  if_nxt;
  timer_wr_t         twr;

  gb_timer #(.DIV_WIDTH(DIV_WIDTH)) u_timer (
    .clk         (clk),
    .reset       (reset),
    .wr          (twr),
    .wdata       (bus_wdata_i),
    .div_q       (div_q),
    .tima_q      (tima_q),
    .tma_q       (tma_q),
    .tac_q       (tac_q),
    .timer_irq_c (timer_irq_c)
  );

  assign wr_req   = bus_req_i & bus_wr_i;
  assign hram_off = bus_addr_i - ADDR_HRAM_BASE;
  assign hram_hit = (bus_addr_i >= ADDR_HRAM_BASE) && (32'(hram_off) < HRAM_DEPTH);

  // Decode, write strobes and read mux; unmapped reads float high
  always_comb begin
    rd_c    = 8'hFF;
    hit_c   = 1'b0;
    twr     = '0;
    if_wr   = 1'b0;
    hram_we = 1'b0;
    case (bus_addr_i)
      ADDR_DIV:  begin hit_c = 1'b1; rd_c = div_q;             twr.div  = wr_req; end
      ADDR_TIMA: begin hit_c = 1'b1; rd_c = tima_q;            twr.tima = wr_req; end
      ADDR_TMA:  begin hit_c = 1'b1; rd_c = tma_q;             twr.tma  = wr_req; end
      ADDR_TAC:  begin hit_c = 1'b1; rd_c = {5'b11111, tac_q}; twr.tac  = wr_req; end
      ADDR_IF:   begin hit_c = 1'b1; rd_c = {3'b111, if_o};    if_wr    = wr_req; end
      default: begin
        if (hram_hit) begin
          hit_c   = 1'b1;
          rd_c    = hram[hram_off[HRAM_AW-1:0]];
          hram_we = wr_req;
        end
      end
    endcase
  end

  // IF: write, then ack clears, then sets win
  always_comb begin
    if_nxt = if_o;
    if (if_wr) if_nxt = bus_wdata_i[IRQ_W-1:0];
    if_nxt = if_nxt & ~irq_ack_i;
    if_nxt = if_nxt | irq_req_i;
    if_nxt[IRQ_TIMER] = if_nxt[IRQ_TIMER] | timer_irq_c;
  end

  always_ff @(posedge clk) begin
    if (hram_we) hram[hram_off[HRAM_AW-1:0]] <= bus_wdata_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_rdata_o  <= 8'h00;
      bus_rvalid_o <= 1'b0;
      bus_hit_o    <= 1'b0;
      if_o         <= '0;
    end else begin
      bus_rvalid_o <= bus_req_i & ~bus_wr_i;
      bus_hit_o    <= bus_req_i & hit_c;
      if (bus_req_i && !bus_wr_i) bus_rdata_o <= rd_c;
      if_o         <= if_nxt;
    end
  end

endmodule

// File: tb/tb_gb_io_responder.sv
// Directed bench for gb_io_responder: vector table plus timer, DIV-glitch and reset sequences.
module tb_gb_io_responder;

`ifdef GB_TIMER_RELOAD_DELAY_EN
  localparam int RD = 4;
  localparam int WO = 2;
`else
  localparam int RD = 0;
  localparam int WO = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_req_i, bus_wr_i;
  logic [15:0] bus_addr_i;
  logic [7:0]  bus_wdata_i, bus_rdata_o;
  logic        bus_rvalid_o, bus_hit_o;
  logic [4:0]  irq_req_i, irq_ack_i, if_o;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        req;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [4:0]  ack;
    logic [4:0]  irq;
    logic        e_rvalid;
    logic        e_hit;
    logic [7:0]  e_rdata;
    logic [4:0]  e_if;
  } vec_t;

  vec_t vt [23];

  always #5 clk = ~clk;

  gb_io_responder dut (
    .clk          (clk),
    .reset        (reset),
    .bus_req_i    (bus_req_i),
    .bus_wr_i     (bus_wr_i),
    .bus_addr_i   (bus_addr_i),
    .bus_wdata_i  (bus_wdata_i),
    .bus_rdata_o  (bus_rdata_o),
    .bus_rvalid_o (bus_rvalid_o),
    .bus_hit_o    (bus_hit_o),
    .irq_req_i    (irq_req_i),
    .irq_ack_i    (irq_ack_i),
    .if_o         (if_o)
  );

  function automatic vec_t mk(input logic req, input logic wr, input logic [15:0] addr,
                              input logic [7:0] wd, input logic [4:0] ack, input logic [4:0] irq,
                              input logic erv, input logic ehit, input logic [7:0] erd,
                              input logic [4:0] eif);
    vec_t v;
    v.req = req; v.wr = wr; v.addr = addr; v.wd = wd; v.ack = ack; v.irq = irq;
    v.e_rvalid = erv; v.e_hit = ehit; v.e_rdata = erd; v.e_if = eif;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  // One clock edge with the given inputs; returns 1 time unit after that edge
  task automatic drive(input logic req, input logic wr, input logic [15:0] addr,
                       input logic [7:0] wd, input logic [4:0] ack, input logic [4:0] irq);
    bus_req_i = req; bus_wr_i = wr; bus_addr_i = addr; bus_wdata_i = wd;
    irq_ack_i = ack; irq_req_i = irq;
    @(posedge clk);
    #1;
    bus_req_i = 1'b0; bus_wr_i = 1'b0; bus_addr_i = 16'h0000; bus_wdata_i = 8'h00;
    irq_ack_i = 5'h00; irq_req_i = 5'h00;
  endtask

  task automatic wr_op(input logic [15:0] addr, input logic [7:0] d);
    drive(1'b1, 1'b1, addr, d, 5'h00, 5'h00);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 16'h0000, 8'h00, 5'h00, 5'h00);
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] addr, input logic [7:0] exp);
    drive(1'b1, 1'b0, addr, 8'h00, 5'h00, 5'h00);
    chk({nm, ".rvalid"}, 8'(bus_rvalid_o), 8'h01);
    chk(nm, bus_rdata_o, exp);
  endtask

  initial begin
    reset = 1'b0;
    bus_req_i = 1'b0; bus_wr_i = 1'b0; bus_addr_i = 16'h0000; bus_wdata_i = 8'h00;
    irq_ack_i = 5'h00; irq_req_i = 5'h00;

    vt[0]  = mk(1, 1, 16'hFF80, 8'h5A, 5'h00, 5'h00, 0, 1, 8'h00, 5'h00);
    vt[1]  = mk(1, 1, 16'hFFFE, 8'hA5, 5'h00, 5'h00, 0, 1, 8'h00, 5'h00);
    vt[2]  = mk(1, 0, 16'hFF80, 8'h00, 5'h00, 5'h00, 1, 1, 8'h5A, 5'h00);
    vt[3]  = mk(1, 0, 16'hFFFE, 8'h00, 5'h00, 5'h00, 1, 1, 8'hA5, 5'h00);
    vt[4]  = mk(1, 0, 16'hFF50, 8'h00, 5'h00, 5'h00, 1, 0, 8'hFF, 5'h00);
    vt[5]  = mk(0, 0, 16'h0000, 8'h00, 5'h00, 5'h00, 0, 0, 8'hFF, 5'h00);
    vt[6]  = mk(1, 1, 16'hFF0F, 8'h00, 5'h01, 5'h01, 0, 1, 8'hFF, 5'h01);
    vt[7]  = mk(0, 0, 16'h0000, 8'h00, 5'h01, 5'h00, 0, 0, 8'hFF, 5'h00);
    vt[8]  = mk(0, 0, 16'h0000, 8'h00, 5'h00, 5'h12, 0, 0, 8'hFF, 5'h12);
    vt[9]  = mk(1, 0, 16'hFF0F, 8'h00, 5'h00, 5'h00, 1, 1, 8'hF2, 5'h12);
    vt[10] = mk(1, 1, 16'hFF0F, 8'h1F, 5'h03, 5'h00, 0, 1, 8'hF2, 5'h1C);
    vt[11] = mk(0, 0, 16'h0000, 8'h00, 5'h1C, 5'h00, 0, 0, 8'hF2, 5'h00);
    vt[12] = mk(1, 0, 16'hFF07, 8'h00, 5'h00, 5'h00, 1, 1, 8'hF8, 5'h00);
    vt[13] = mk(1, 0, 16'hFF06, 8'h00, 5'h00, 5'h00, 1, 1, 8'h00, 5'h00);
    vt[14] = mk(1, 1, 16'hFF06, 8'hAB, 5'h00, 5'h00, 0, 1, 8'h00, 5'h00);
    vt[15] = mk(1, 0, 16'hFF06, 8'h00, 5'h00, 5'h00, 1, 1, 8'hAB, 5'h00);
    vt[16] = mk(1, 1, 16'hFF07, 8'h1A, 5'h00, 5'h00, 0, 1, 8'hAB, 5'h00);
    vt[17] = mk(1, 0, 16'hFF07, 8'h00, 5'h00, 5'h00, 1, 1, 8'hFA, 5'h00);
    vt[18] = mk(1, 0, 16'hFF05, 8'h00, 5'h00, 5'h00, 1, 1, 8'h00, 5'h00);
    vt[19] = mk(1, 0, 16'hFFFF, 8'h00, 5'h00, 5'h00, 1, 0, 8'hFF, 5'h00);
    vt[20] = mk(1, 0, 16'hFF7F, 8'h00, 5'h00, 5'h00, 1, 0, 8'hFF, 5'h00);
    vt[21] = mk(1, 1, 16'hFF07, 8'h00, 5'h00, 5'h00, 0, 1, 8'hFF, 5'h00);
    vt[22] = mk(1, 0, 16'hFF04, 8'h00, 5'h00, 5'h00, 1, 1, 8'h00, 5'h00);

    // Reset state
    #12;
    chk("rst.rvalid", 8'(bus_rvalid_o), 8'h00);
    chk("rst.hit", 8'(bus_hit_o), 8'h00);
    chk("rst.rdata", bus_rdata_o, 8'h00);
    chk("rst.if", 8'(if_o), 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Table: HRAM, unmapped, IF priority, register formats
    for (int i = 0; i < 23; i++) begin
      drive(vt[i].req, vt[i].wr, vt[i].addr, vt[i].wd, vt[i].ack, vt[i].irq);
      chk($sformatf("v%0d.rvalid", i), 8'(bus_rvalid_o), 8'(vt[i].e_rvalid));
      chk($sformatf("v%0d.hit", i), 8'(bus_hit_o), 8'(vt[i].e_hit));
      chk($sformatf("v%0d.rdata", i), bus_rdata_o, vt[i].e_rdata);
      chk($sformatf("v%0d.if", i), 8'(if_o), 8'(vt[i].e_if));
    end

    // Timer overflow: DIV cleared at edge E, TIMA=FE at E+1, falls at E+16 and E+32
    wr_op(16'hFF07, 8'h05);
    wr_op(16'hFF06, 8'hF0);
    wr_op(16'hFF04, 8'h00);
    wr_op(16'hFF05, 8'hFE);
    idle(30 + RD);
    chk("ovf.if_before", 8'(if_o), 8'h00);
    idle(1);
    chk("ovf.if_after", 8'(if_o), 8'h04);
    rd_chk("ovf.tima", 16'hFF05, 8'hF0);
    rd_chk("ovf.if_read", 16'hFF0F, 8'hE4);

    // TIMA write in the overflow clk (delay clk 2 when the reload delay is built in)
    wr_op(16'hFF0F, 8'h00);
    wr_op(16'hFF04, 8'h00);
    wr_op(16'hFF05, 8'hFE);
    idle(30 + WO);
    wr_op(16'hFF05, 8'h33);
    idle(6);
    chk("tima_wr.if", 8'(if_o), 8'h00);
    rd_chk("tima_wr.tima", 16'hFF05, 8'h33);

    // TMA write in the overflow clk feeds the reload
    wr_op(16'hFF04, 8'h00);
    wr_op(16'hFF05, 8'hFE);
    idle(30 + WO);
    chk("tma_wr.if_before", 8'(if_o), 8'h00);
    wr_op(16'hFF06, 8'h77);
    idle(RD - WO);
    chk("tma_wr.if_after", 8'(if_o), 8'h04);
    rd_chk("tma_wr.tima", 16'hFF05, 8'h77);
    wr_op(16'hFF0F, 8'h00);

    // DIV write while divider[9]=1 glitches exactly one TIMA tick
    wr_op(16'hFF07, 8'h04);
    wr_op(16'hFF04, 8'h00);
    wr_op(16'hFF05, 8'h10);
    idle(597);
    rd_chk("glitch.div_pre", 16'hFF04, 8'h02);
    wr_op(16'hFF04, 8'hC3);
    rd_chk("glitch.div_post", 16'hFF04, 8'h00);
    rd_chk("glitch.tima", 16'hFF05, 8'h11);

    // Asynchronous reset mid-operation
    wr_op(16'hFF0F, 8'h1F);
    chk("prerst.if", 8'(if_o), 8'h1F);
    rd_chk("prerst.hram", 16'hFF80, 8'h5A);
    #2;
    reset = 1'b0;
    #1;
    chk("arst.if", 8'(if_o), 8'h00);
    chk("arst.rvalid", 8'(bus_rvalid_o), 8'h00);
    chk("arst.hit", 8'(bus_hit_o), 8'h00);
    chk("arst.rdata", bus_rdata_o, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b1;
    rd_chk("post.hram0", 16'hFF80, 8'h5A);
    rd_chk("post.hram1", 16'hFFFE, 8'hA5);
    rd_chk("post.tima", 16'hFF05, 8'h00);
    rd_chk("post.tma", 16'hFF06, 8'h00);
    rd_chk("post.tac", 16'hFF07, 8'hF8);
    rd_chk("post.if", 16'hFF0F, 8'hE0);
    rd_chk("post.div", 16'hFF04, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
